bellek_hakemi: RTL
==================

// Module: bellek_hakemi
// PURPOSE
//   Two-requester arbiter for the single-port main memory. Port 0 is the multi-cycle core (islemci);
//   port 1 is the loader/DMA side. One access at a time; fixed memory read latency; per-port
//   request/done handshake. Sits between both masters and the memory model.
// PARAMETERS
//   VERI_BIT         32             data width
//   ADRES_BIT        32             address width
//   BELLEK_GECIKME   1              memory cycles per access (>=1); read data valid in last ERISIM cycle
//   SABIT_ONCELIK    0              0: round-robin; 1: port 0 always wins
//   BASLANGIC_ADRES  32'h8000_0000  bellek_adres value after reset
// PORTS
//   clk              in   1          clock
//   rst              in   1          synchronous, active-high reset
//   istek_0          in   1          port 0 request; held with adres/yaz/veri until tamam_0
//   adres_0          in   ADRES_BIT  port 0 address
//   yaz_0            in   1          port 0: 1 = write, 0 = read
//   yaz_veri_0       in   VERI_BIT   port 0 write data
//   tamam_0          out  1          port 0 done, 1-cycle pulse
//   oku_veri_0       out  VERI_BIT   port 0 read data, valid while tamam_0=1
//   istek_1, adres_1, yaz_1, yaz_veri_1, tamam_1, oku_veri_1   same as port 0, for port 1
//   bellek_adres     out  ADRES_BIT  memory address
//   bellek_yaz       out  1          memory write strobe
//   bellek_yaz_veri  out  VERI_BIT   memory write data
//   bellek_oku_veri  in   VERI_BIT   memory read data
// BEHAVIOUR
//   States: BOSTA -> ERISIM (BELLEK_GECIKME cycles) -> YANIT (1 cycle) -> BOSTA.
//   BOSTA
//     - No istek: stay.
//     - Any istek: pick the winner; latch its adres/yaz/yaz_veri and id; load sayac=BELLEK_GECIKME-1;
//       go to ERISIM.
//   Arbitration
//     - Only one port requesting: that port wins.
//     - Both requesting, SABIT_ONCELIK=0: oncelik pointer wins, then pointer <= other port.
//     - Both requesting, SABIT_ONCELIK=1: port 0 wins.
//     - Single-requester grant also sets pointer to the other port.
//   ERISIM
//     - bellek_adres/bellek_yaz_veri driven from latched registers; later input changes are ignored.
//     - bellek_yaz=1 only in the first ERISIM cycle of a write; 0 otherwise.
//     - sayac decrements each cycle. When sayac==0: capture bellek_oku_veri (reads only) into
//       oku_veri_<id>; go to YANIT.
//   YANIT
//     - tamam_<id>=1 for exactly this cycle; other port's tamam=0; go to BOSTA.
//     - Requester must drop or replace istek on the next edge. BOSTA re-samples istek fresh.
//   Latency
//     - Request sampled in BOSTA at cycle 0 -> tamam at cycle BELLEK_GECIKME+1.
//     - Back-to-back accesses every BELLEK_GECIKME+2 cycles.
//   Idle outputs (BOSTA, YANIT)
//     - bellek_yaz=0; bellek_adres holds the last driven value; oku_veri_x holds last captured data.
//   Writes: oku_veri of the owner is unchanged.
//   Address: passed through unmodified; no alignment check.
//   istek arriving during ERISIM/YANIT: waits; considered only in BOSTA.
//   Reset, any state, next cycle:
//     - state=BOSTA, oncelik=0, tamam_0/1=0, bellek_yaz=0, bellek_adres=BASLANGIC_ADRES,
//       bellek_yaz_veri=0, oku_veri_0/1=0, sayac=0.
//     - Aborted access produces no tamam.
// TESTING
//   1 G=1, read: istek_0 adres_0=0x8000_0010 at c0, mem returns 0xDEAD_BEEF -> bellek_adres=0x8000_0010
//     at c1; tamam_0=1, oku_veri_0=0xDEAD_BEEF at c2; tamam_1=0 throughout.
//   2 G=3, write: istek_1 adres_1=0x8000_0100 veri=0x1234_5678 -> bellek_yaz=1 only at c1; adres held
//     c1-c3; tamam_1 at c4; yaz_veri_1 changed at c2 not seen on bellek_yaz_veri.
//   3 RR, G=1, istek_0 and istek_1 held high after reset (re-asserted after each tamam) -> tamam order
//     0,1,0,1; one grant every 3 cycles.
//   4 SABIT_ONCELIK=1, both requesting continuously -> only tamam_0 pulses over 20 cycles; tamam_1
//     follows the first cycle istek_0 drops.
//   5 G=3 write, rst high at c2 (mid-ERISIM) -> c3: bellek_yaz=0, bellek_adres=0x8000_0000, no tamam;
//     next istek_1 and istek_0 together grants port 0 (oncelik reset).
//   6 istek_1 rises during port 0 ERISIM -> port 1 granted in first BOSTA after tamam_0; port 0 not
//     double-served.

Source files
------------

// File: rtl/bellek_hakemi.sv
// Two-port arbiter in front of the single-port main memory.
// Port 0 is the core and port 1 is the loader/DMA side. One access runs at a time.
module bellek_hakemi #(
   parameter int                   VERI_BIT        = 32,
   parameter int                   ADRES_BIT       = 32,
   parameter int                   BELLEK_GECIKME  = 1,
   parameter int                   SABIT_ONCELIK   = 0,
   parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 istek_0,
   input  logic [ADRES_BIT-1:0] adres_0,
   input  logic                 yaz_0,
   input  logic [VERI_BIT-1:0]  yaz_veri_0,
   output logic                 tamam_0,
   output logic [VERI_BIT-1:0]  oku_veri_0,
   input  logic                 istek_1,
   input  logic [ADRES_BIT-1:0] adres_1,
   input  logic                 yaz_1,
   input  logic [VERI_BIT-1:0]  yaz_veri_1,
   output logic                 tamam_1,
   output logic [VERI_BIT-1:0]  oku_veri_1,
   output logic [ADRES_BIT-1:0] bellek_adres,
   output logic                 bellek_yaz,
   output logic [VERI_BIT-1:0]  bellek_yaz_veri,
   input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

   // state  | meaning
   // BOSTA  | idle, sampling both requests
   // ERISIM | memory access in progress for BELLEK_GECIKME cycles
   // YANIT  | one-cycle done pulse to the owner
   localparam logic [1:0] BOSTA  = 2'd0;
   localparam logic [1:0] ERISIM = 2'd1;
   localparam logic [1:0] YANIT  = 2'd2;

   localparam int SAYAC_BIT = (BELLEK_GECIKME > 1) ? $clog2(BELLEK_GECIKME) : 1;
   localparam logic [SAYAC_BIT-1:0] SAYAC_YUK = SAYAC_BIT'(BELLEK_GECIKME - 1);

   logic [1:0]           durum;
   logic                 oncelik;
   logic                 sahip;
   logic                 lat_yaz;
   logic [SAYAC_BIT-1:0] sayac;
   logic                 kazanan;

   always_comb begin
      kazanan = 1'b0;
      if (istek_0 && istek_1)
         kazanan = (SABIT_ONCELIK != 0) ? 1'b0 : oncelik;
      else if (istek_1)
         kazanan = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         durum           <= BOSTA;
         oncelik         <= 1'b0;
         sahip           <= 1'b0;
         lat_yaz         <= 1'b0;
         sayac           <= '0;
         tamam_0         <= 1'b0;
         tamam_1         <= 1'b0;
         bellek_yaz      <= 1'b0;
         bellek_adres    <= BASLANGIC_ADRES;
         bellek_yaz_veri <= '0;
         oku_veri_0      <= '0;
         oku_veri_1      <= '0;
      end else begin
         bellek_yaz <= 1'b0;
         tamam_0    <= 1'b0;
         tamam_1    <= 1'b0;
         case (durum)
            BOSTA: begin
               if (istek_0 || istek_1) begin
                  sahip           <= kazanan;
                  oncelik         <= ~kazanan;
                  lat_yaz         <= kazanan ? yaz_1 : yaz_0;
                  bellek_yaz      <= kazanan ? yaz_1 : yaz_0;
                  bellek_adres    <= kazanan ? adres_1 : adres_0;
                  bellek_yaz_veri <= kazanan ? yaz_veri_1 : yaz_veri_0;
                  sayac           <= SAYAC_YUK;
                  durum           <= ERISIM;
               end
            end
            ERISIM: begin
               if (sayac == '0) begin
                  if (!lat_yaz) begin
                     if (sahip) oku_veri_1 <= bellek_oku_veri;
                     else       oku_veri_0 <= bellek_oku_veri;
                  end
                  tamam_0 <= ~sahip;
                  tamam_1 <= sahip;
                  durum   <= YANIT;
               end else begin
                  sayac <= sayac - 1'b1;
               end
            end
            YANIT:   durum <= BOSTA;
            default: durum <= BOSTA;
         endcase
      end
   end

endmodule
